// File: rtl/palette_ram_multiport.sv
`default_nettype none
// ============================================================================
// Module   : palette_ram_multiport
// Purpose  : Palette RAM with one write port and NUM_RD registered read ports.
//            A clear sequencer zeroes the whole array after reset or on
//            request, one entry per cycle. With PALETTE_DOUBLE_BUF_EN defined
//            the palette is double-buffered: writes go to the back bank,
//            reads come from the front bank, and swap_req exchanges them.
// Config   : PALETTE_DOUBLE_BUF_EN - enables the two-bank double buffer.
// Ports    : clk, rst (async, active-low)
//            wr_en/wr_addr/wr_data, wr_ready    - write port
//            rd_en/rd_addr -> rd_data/rd_valid  - NUM_RD read ports, latency 1
//            clear_req -> clear_busy            - palette clear
//            swap_req  -> front_bank            - bank swap
// Revision : 1.0 - initial release
// ============================================================================
module palette_ram_multiport #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10,
   parameter int NUM_RD = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       wr_ready,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_valid,
   input  logic                       clear_req,
   output logic                       clear_busy,
   input  logic                       swap_req,
   output logic                       front_bank
);

   localparam int                c_DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_clrPtr;
   logic              r_clearBusy;
   logic              w_clrDone;

   // Last clear write happens this cycle unless a new clear request restarts it.
   assign w_clrDone = (r_clrPtr == c_LAST_ADDR) && !clear_req;

`ifdef PALETTE_DOUBLE_BUF_EN
   logic r_front;
   logic r_swapPend;
   logic w_wrBank;

   assign w_wrBank   = ~r_front;
   assign front_bank = r_front;
`else
   logic w_unusedSwap;

   assign w_unusedSwap = swap_req;
   assign front_bank   = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Clear sequencer / bank control
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_CLEAR;
         r_clrPtr    <= '0;
         r_clearBusy <= 1'b1;
`ifdef PALETTE_DOUBLE_BUF_EN
         r_front     <= 1'b0;
         r_swapPend  <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (clear_req) begin
                  r_clrPtr <= '0;
               end else if (w_clrDone) begin
                  r_state     <= ST_IDLE;
                  r_clearBusy <= 1'b0;
                  r_clrPtr    <= '0;
               end else begin
                  r_clrPtr <= r_clrPtr + ADDR_W'(1);
               end
`ifdef PALETTE_DOUBLE_BUF_EN
               // A deferred swap takes effect together with the return to
               // IDLE, so the new front bank is visible on the first IDLE
               // cycle. Repeated requests collapse into one pending swap.
               if (w_clrDone && (r_swapPend || swap_req)) begin
                  r_front    <= ~r_front;
                  r_swapPend <= 1'b0;
               end else if (swap_req) begin
                  r_swapPend <= 1'b1;
               end
`endif
            end
            default: begin
               if (clear_req) begin
                  r_state     <= ST_CLEAR;
                  r_clearBusy <= 1'b1;
                  r_clrPtr    <= '0;
               end
`ifdef PALETTE_DOUBLE_BUF_EN
               if (swap_req) begin
                  r_front <= ~r_front;
               end
`endif
            end
         endcase
      end
   end

   assign clear_busy = r_clearBusy;
   assign wr_ready   = ~r_clearBusy;

   // ------------------------------------------------------------------------
   // Storage: not reset; the clear sequencer owns initialisation.
   // ------------------------------------------------------------------------
`ifdef PALETTE_DOUBLE_BUF_EN
   logic [DATA_W-1:0] r_mem [2][c_DEPTH];

   always_ff @(posedge clk) begin
      if (r_clearBusy) begin
         r_mem[0][r_clrPtr] <= '0;
         r_mem[1][r_clrPtr] <= '0;
      end else if (wr_en) begin
         r_mem[w_wrBank][wr_addr] <= wr_data;
      end
   end
`else
   logic [DATA_W-1:0] r_mem [c_DEPTH];

   always_ff @(posedge clk) begin
      if (r_clearBusy) begin
         r_mem[r_clrPtr] <= '0;
      end else if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Read ports: registered, read-first against a same-cycle write because
   // the array update and the read sample happen on the same edge.
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rdPort
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] r_data;
      logic              r_valid;

      assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
         end else begin
            r_valid <= rd_en[i];
            if (rd_en[i]) begin
`ifdef PALETTE_DOUBLE_BUF_EN
               r_data <= r_mem[r_front][w_addr];
`else
               r_data <= r_mem[w_addr];
`endif
            end
         end
      end

      assign rd_data[i*DATA_W +: DATA_W] = r_data;
      assign rd_valid[i]                 = r_valid;
   end

endmodule
`default_nettype wire
